// File: rtl/ttl_macros.sv
// Shared 2D bus helpers for the chip library: convert between the library's
// interleaved packed buses (minor index = block) and [block][index] arrays.
`ifndef TTL_MACROS_SV
`define TTL_MACROS_SV

`define ASSIGN_UNPACK(OUTER, INNER, DEST, SRC) \
   for (genvar gi_unpk = 0; gi_unpk < (OUTER); gi_unpk++) begin : g_unpk \
      for (genvar gj_unpk = 0; gj_unpk < (INNER); gj_unpk++) begin : g_unpk_inner \
         assign DEST[gi_unpk][gj_unpk] = SRC[gj_unpk*(OUTER) + gi_unpk]; \
      end \
   end

`define ASSIGN_PACK(OUTER, INNER, DEST, SRC) \
   for (genvar gi_pk = 0; gi_pk < (OUTER); gi_pk++) begin : g_pk \
      for (genvar gj_pk = 0; gj_pk < (INNER); gj_pk++) begin : g_pk_inner \
         assign DEST[gj_pk*(OUTER) + gi_pk] = SRC[gi_pk][gj_pk]; \
      end \
   end

`endif

// File: rtl/ttl_74164.sv
// 74164-style serial-in/parallel-out shift register: per block, the serial
// inputs are ANDed and shifted into a WIDTH_OUT-stage register.
`include "ttl_macros.sv"

module ttl_74164 #(
   parameter int BLOCKS     = 1,
   parameter int WIDTH_IN   = 2,
   parameter int WIDTH_OUT  = 8,
   parameter int DELAY_RISE = 0,
   parameter int DELAY_FALL = 0
) (
   input  logic                          Clk,
   input  logic                          Clear,
   input  logic                          Clk_Inhibit,
   input  logic [BLOCKS*WIDTH_IN-1:0]    A_2D,
   output logic [BLOCKS*WIDTH_OUT-1:0]   Q_2D
);

   logic [BLOCKS-1:0][WIDTH_IN-1:0]  a_unpacked;
   logic [BLOCKS-1:0]                serial_in;
   logic [BLOCKS-1:0][WIDTH_OUT-1:0] q_unpacked;
   logic [BLOCKS*WIDTH_OUT-1:0]      q_packed;

   `ASSIGN_UNPACK(BLOCKS, WIDTH_IN, a_unpacked, A_2D)

   // Any low input gates a 0 into the register, so one input can act as enable.
   always_comb begin
      serial_in = '0;
      for (int b = 0; b < BLOCKS; b++) begin
         serial_in[b] = &a_unpacked[b];
      end
   end

   for (genvar gi = 0; gi < BLOCKS; gi++) begin : g_block
      logic [WIDTH_OUT-1:0] stage_reg;

      if (WIDTH_OUT == 1) begin : g_single
         always_ff @(posedge Clk) begin
            if (Clear) begin
               stage_reg <= '0;
            end else if (!Clk_Inhibit) begin
               stage_reg <= serial_in[gi];
            end
         end
      end else begin : g_multi
         always_ff @(posedge Clk) begin
            if (Clear) begin
               stage_reg <= '0;
            end else if (!Clk_Inhibit) begin
               stage_reg <= {stage_reg[WIDTH_OUT-2:0], serial_in[gi]};
            end
         end
      end

      assign q_unpacked[gi] = stage_reg;
   end

   `ASSIGN_PACK(BLOCKS, WIDTH_OUT, q_packed, q_unpacked)

   if (DELAY_RISE == 0 && DELAY_FALL == 0) begin : g_no_delay
      assign Q_2D = q_packed;
   end else begin : g_delay
      // Two uniformly delayed copies; AND/OR picks the slower copy for the
      // rising or falling transition so each edge gets its own delay.
      logic [BLOCKS*WIDTH_OUT-1:0] q_rise;
      logic [BLOCKS*WIDTH_OUT-1:0] q_fall;
      assign #(DELAY_RISE) q_rise = q_packed;
      assign #(DELAY_FALL) q_fall = q_packed;
      if (DELAY_RISE >= DELAY_FALL) begin : g_rise_slow
         assign Q_2D = q_rise & q_fall;
      end else begin : g_fall_slow
         assign Q_2D = q_rise | q_fall;
      end
   end

endmodule

// File: doc/ttl_74164.md
Name: ttl_74164

Overview:
- Serial-in, parallel-out shift register in the 7400-series chip library: the one-to-many counterpart of the library's many-to-one gates.
- Per block, WIDTH_IN serial data inputs are ANDed into one serial bit, which is shifted into a WIDTH_OUT-bit register presented in parallel.
- Default configuration is the 74164: one 8-bit block with two ANDed serial inputs (A, B).
- Used as a building block in larger chip-level netlists and as a deserializer stage in board models.

Parameters:
- BLOCKS, 1, number of independent shift registers (all share clock, clear and inhibit).
- WIDTH_IN, 2, number of serial inputs ANDed per block.
- WIDTH_OUT, 8, stages per shift register.
- DELAY_RISE, 0, output rise delay applied to Q_2D.
- DELAY_FALL, 0, output fall delay applied to Q_2D.

Ports:
- Clk  input  1  clock; all state changes on its rising edge.
- Clear  input  1  synchronous active-high clear.
- Clk_Inhibit  input  1  active-high; when set, shifting is suppressed and state holds.
- A_2D  input  BLOCKS*WIDTH_IN  serial inputs; input i of block b at bit i*BLOCKS+b, matching the library's 2D packing.
- Q_2D  output  BLOCKS*WIDTH_OUT  parallel outputs; stage k of block b at bit k*BLOCKS+b; stage 0 is first-in (QA).

Behaviour:
- Single clock domain. Reset is synchronous and active-high: Clear is sampled only on the rising edge of Clk.
- Register state before the first qualifying edge is X in simulation. No power-on value is implied.
- Priority at each rising Clk edge:
  1. Clear=1: all stages of all blocks become 0. Clk_Inhibit and A_2D are ignored.
  2. Else Clk_Inhibit=1: all stages hold.
  3. Else shift: stage 0 takes the AND of the block's WIDTH_IN serial inputs; stage k takes the old stage k-1 for k = 1..WIDTH_OUT-1; the old last stage is discarded.
- Latency: a serial bit applied before edge n appears on stage 0 after edge n, and on stage WIDTH_OUT-1 after edge n+WIDTH_OUT-1. Inhibited edges do not count.
- Serial gating: if any input of a block is 0, a 0 is shifted in. This allows one input to act as a data enable.
- Blocks are fully independent except for the shared Clk, Clear and Clk_Inhibit.
- Simultaneous events:
  - Clear with Clk_Inhibit: clear wins.
  - Clear deasserted on an edge with Clk_Inhibit=0: that edge shifts normally.
- Clear mid-stream discards all partially shifted data. Shifting resumes from all-zero on the next qualifying edge.
- Inputs changing between edges have no effect. There is no asynchronous path from A_2D to Q_2D.
- Output timing: Q_2D follows the register through #(DELAY_RISE, DELAY_FALL). With both delays at 0, the output equals the register state immediately after the edge.
- Degenerate widths:
  - WIDTH_IN=1: the input is passed straight through.
  - WIDTH_OUT=1: a single D flip-flop with enable and clear.
- No parameter checking is required. BLOCKS, WIDTH_IN and WIDTH_OUT are each at least 1.

Decomposition:
- 2D pack/unpack handling uses the library's shared ASSIGN_UNPACK macro for A_2D. Q_2D packing uses the companion ASSIGN_PACK macro.
- Add ASSIGN_PACK to the shared macro header if absent. No module-local copies of either macro.
- No package types are needed. The shifted-in bit per block is a WIDTH_IN AND-reduction computed in a combinational always block.
- No sub-module: a generate loop over BLOCKS with one clocked always block holding an array of WIDTH_OUT-bit registers.

Test Plan:
- Clear then shift: Clear=1 for 1 edge -> Q=8'h00; then A=B=1 for 3 edges -> Q=8'h07; then A=1,B=0 for 2 edges -> Q=8'h1C.
- Full traversal: after clear, apply serial pattern 1,0,1,1,0,0,1,0 (first bit first) over 8 edges -> Q stage0..7 = 0,1,0,0,1,1,0,1 (Q=8'hB2); a 9th edge with input 0 -> Q=8'h64.
- Inhibit: load Q=8'h5A, set Clk_Inhibit=1 for 4 edges while toggling A/B -> Q stays 8'h5A; release with A=B=1 -> Q=8'hB5.
- Clear priority and mid-stream clear: Q=8'hFF, Clear=1 with Clk_Inhibit=1 -> Q=8'h00 on that edge. Clear pulsed for one cycle mid-stream -> next shifted bits start from zero.
- Synchronous clear: assert Clear between edges -> Q unchanged until the next rising Clk, then 8'h00.
- Multi-block/parameters: BLOCKS=2, WIDTH_IN=3, WIDTH_OUT=4, block0 inputs all 1, block1 inputs {1,1,0}, 4 edges -> block0 = 4'hF, block1 = 4'h0. With DELAY_RISE=10, DELAY_FALL=5, Q edges lag the clock edge by 10/5.
